// File: rtl/echo_pkg.sv
// Shared types and constants for the echo mixer.
// Contents:
//   state_e          - control states (IDLE, PRIME, RUN)
//   DATA_W_DEF       - default sample width
//   GAIN_W_DEF       - default gain width
//   SAT_MAX_DEF      - saturation ceiling at the default sample width
package echo_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_e;

  localparam int DATA_W_DEF = 8;
  localparam int GAIN_W_DEF = 3;
  localparam logic [DATA_W_DEF-1:0] SAT_MAX_DEF = '1;
endpackage

// File: rtl/echo_mixer_if.sv
// Sample bus for the echo mixer.
// Signals:
//   clear     - synchronous flush request
//   in_valid  - qualifies in_data / dly_data / gain
//   in_data   - direct sample
//   dly_data  - delayed sample from the upstream delay line
//   gain      - echo gain, scale gain / 2^GAIN_W
//   out_valid - qualifies out_data
//   out_data  - mixed, saturated sample
//   primed    - high while the mixer is in RUN
// master drives the inputs, slave is the mixer side.
interface echo_mixer_if
  import echo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int GAIN_W = GAIN_W_DEF
);
  logic              clear;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] dly_data;
  logic [GAIN_W-1:0] gain;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              primed;

  modport master (
    output clear, in_valid, in_data, dly_data, gain,
    input  out_valid, out_data, primed
  );

  modport slave (
    input  clear, in_valid, in_data, dly_data, gain,
    output out_valid, out_data, primed
  );
endinterface

// File: rtl/echo_sat_add.sv
// Combinational unsigned saturating adder for the stage-2 mix.
// Ports:
//   i_a, i_b - unsigned operands
//   o_sum    - i_a + i_b, clamped to the all-ones value
module echo_sat_add #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_sum
);
  logic [DATA_W:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b};
  // Carry out means the true sum exceeds the ceiling.
  assign o_sum  = w_full[DATA_W] ? {DATA_W{1'b1}} : w_full[DATA_W-1:0];
endmodule

// File: rtl/echo_mixer.sv
// Echo mixer: out = sat(in_data + (dly_data * gain) >> GAIN_W).
// The echo term is held at zero until DELAY samples have been accepted,
// since the upstream delay line carries no valid data before then.
// Two-stage pipeline, one sample per cycle, no back-pressure.
// Ports:
//   i_clock - clock, rising edge
//   i_reset - synchronous active-high reset
//   bus     - sample bus (slave side), see echo_mixer_if
module echo_mixer
  import echo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int GAIN_W = GAIN_W_DEF,
  parameter int DELAY  = 30
) (
  input  logic        i_clock,
  input  logic        i_reset,
  echo_mixer_if.slave bus
);
  // Counter only needs to reach DELAY; keep at least one bit for DELAY=0.
  localparam int CNT_W = (DELAY > 0) ? $clog2(DELAY + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DELAY);
  localparam int PROD_W = DATA_W + GAIN_W;

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_PRIME = PRIME;
  localparam logic [1:0] S_RUN   = RUN;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_vld_pipe;    // [0] stage 1, [1] stage 2
  logic [DATA_W-1:0] r_s1_data;
  logic [DATA_W-1:0] r_s1_echo;
  logic [DATA_W-1:0] r_out_data;

  logic              w_accept;
  logic              w_mix;
  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [PROD_W-1:0] w_prod;
  logic [DATA_W-1:0] w_echo;
  logic [DATA_W-1:0] w_sum;

  // clear drops the sample presented in the same cycle.
  assign w_accept  = bus.in_valid & ~bus.clear;
  assign w_cnt_inc = r_cnt + 1'b1;

  // Mixing applies to samples accepted in RUN, or to the very first
  // sample when there is no delay to wait out.
  always_comb begin
    w_mix = 1'b0;
    case (r_state)
      S_IDLE:  w_mix = (DELAY == 0);
      S_RUN:   w_mix = 1'b1;
      default: w_mix = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_accept) begin
      case (r_state)
        S_IDLE: begin
          if (DELAY == 0) begin
            w_state_nxt = S_RUN;
          end else begin
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = (DELAY == 1) ? S_RUN : S_PRIME;
          end
        end
        S_PRIME: begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == CNT_MAX) w_state_nxt = S_RUN;
        end
        default: begin
          // RUN holds; counter already sits at DELAY.
          w_state_nxt = r_state;
          w_cnt_nxt   = r_cnt;
        end
      endcase
    end
  end

  // Full-width product before the shift so no high bits are lost.
  assign w_prod = {{GAIN_W{1'b0}}, bus.dly_data} * {{DATA_W{1'b0}}, bus.gain};
  assign w_echo = w_mix ? w_prod[PROD_W-1:GAIN_W] : '0;

  echo_sat_add #(.DATA_W(DATA_W)) u_sat_add (
    .i_a   (r_s1_data),
    .i_b   (r_s1_echo),
    .o_sum (w_sum)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_vld_pipe <= '0;
      r_s1_data  <= '0;
      r_s1_echo  <= '0;
      r_out_data <= '0;
    end else if (bus.clear) begin
      // Kill both in-flight valids; out_data keeps its last value.
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_vld_pipe <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_vld_pipe <= {r_vld_pipe[0], w_accept};
      if (w_accept) begin
        r_s1_data <= bus.in_data;
        r_s1_echo <= w_echo;
      end
      if (r_vld_pipe[0]) r_out_data <= w_sum;
    end
  end

  assign bus.out_valid = r_vld_pipe[1];
  assign bus.out_data  = r_out_data;
  assign bus.primed    = (r_state == S_RUN);
endmodule
